// File: rtl/multicycle_ctrl.sv
// Multicycle controller: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing for
// add, addi, lw, sw and j, plus a sticky illegal flag and retire counter.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   inst       instruction register value (opcode [31:26], funct [5:0])
//   mem_ack    memory completes the outstanding request this cycle
//   mem_req    memory access request
//   mem_we     request is a write
//   addr_sel   0 = PC, 1 = ALU result as memory address
//   ir_we      load instruction register from memory read data
//   pc_we      PC write enable
//   pc_src     0 = PC+4, 1 = jump target
//   reg_we     register file write enable
//   reg_dst    0 = rt, 1 = rd
//   reg_src    0 = ALU, 1 = memory
//   alu_src    0 = register, 1 = immediate
//   alu_ctrl   3'b010 = ADD, 3'b000 otherwise
//   illegal    sticky unsupported-instruction flag
//   state      current FSM state (debug)
//   instret    retired-instruction count, wraps silently
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             reg_src,
    output logic             alu_src,
    output logic [2:0]       alu_ctrl,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOP = 3'b000;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_add, is_addi, is_lw, is_sw, is_j;
    logic       ack;
    logic       retire;
    state_e     cur;
    logic       unused_inst;

    assign opcode      = inst[31:26];
    assign funct       = inst[5:0];
    assign unused_inst = ^inst[25:6];

    assign is_add  = (opcode == 6'b000000) && (funct == 6'b100000);
    assign is_addi = (opcode == 6'b001000);
    assign is_lw   = (opcode == 6'b100011);
    assign is_sw   = (opcode == 6'b101011);
    assign is_j    = (opcode == 6'b000010);

    // While reset is high the strobes must look like an unacknowledged
    // FETCH, whatever state the register currently holds.
    assign ack = mem_ack & ~reset;
    assign cur = reset ? FETCH : state_q;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        reg_we    = 1'b0;
        reg_dst   = 1'b0;
        reg_src   = 1'b0;
        alu_src   = 1'b0;
        alu_ctrl  = ALU_NOP;
        unique case (cur)
            FETCH: begin
                mem_req = 1'b1;
                if (ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                unique case (1'b1)
                    is_j: begin
                        pc_we   = 1'b1;
                        pc_src  = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    is_add, is_addi, is_lw, is_sw: begin
                        state_d = EXEC;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = HALT;
                    end
                endcase
            end
            EXEC: begin
                alu_ctrl = ALU_ADD;
                alu_src  = ~is_add;
                state_d  = (is_lw || is_sw) ? MEM : WB;
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                alu_src  = 1'b1;
                alu_ctrl = ALU_ADD;
                mem_we   = is_sw;
                if (ack) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                reg_we  = 1'b1;
                reg_dst = is_add;
                reg_src = is_lw;
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign instret_d = instret_q + CNT_W'(retire);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule
